jk_excitation_driver: RTL and testbench
=======================================

Name: jk_excitation_driver

Overview:
- Driver that sits on the input side of a WIDTH-bit bank of JK flip-flops, which share clk with this block.
- Accepts a write request (load a target word, or toggle under a mask) over a valid/ready handshake.
- Turns the request into one cycle of J/K excitation, waits for the bank to settle, reads the bank's Q back and checks it.
- On a mismatch it retries a bounded number of times, then reports done or err.

Parameters:
- WIDTH, 8, number of JK bits driven.
- SETTLE_CYCLES, 1, idle cycles between a drive and the Q check; must be >= 1.
- MAX_RETRY, 2, extra drive attempts after the first mismatch; 0 means no retry.

Ports:
- clk  in  1  clock; the JK bank uses the same clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; decoded from state.
- req_mode  in  1  0 = LOAD target, 1 = TOGGLE mask.
- req_data  in  WIDTH  target word in LOAD, mask in TOGGLE.
- q_in  in  WIDTH  Q feedback from the JK bank.
- j  out  WIDTH  registered J drive to the bank.
- k  out  WIDTH  registered K drive to the bank.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: operation verified.
- err  out  1  one-cycle pulse: retries exhausted.
- err_bits  out  WIDTH  expected XOR q_in at failure; held until the next acceptance.

Behaviour:
- Reset (rst low, async): state IDLE; j, k, done, err, err_bits all zero; retry counter zero. Because state is IDLE, req_ready reads 1 during reset, but no request is captured while rst is low.
- Acceptance: req_valid && req_ready during cycle N.
  - expected is registered as req_data (LOAD) or q_in ^ req_data (TOGGLE, using q_in sampled in cycle N).
  - The retry counter is cleared and err_bits is cleared.
- Excitation, per bit, with q the current q_in and t the expected bit:
  - LOAD first drive and every retry: q=0,t=1 gives j=1,k=0. q=1,t=0 gives j=0,k=1. q equal to t gives j=0,k=0. The 11 code is never used in LOAD.
  - TOGGLE first drive: j = k = mask. Retries of a TOGGLE use LOAD-style excitation toward expected.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
  - IDLE: j = k = 0. On acceptance go to DRIVE.
  - DRIVE (cycle N+1): j/k hold the computed excitation for exactly one cycle. The bank captures it at the end of this cycle. Next state SETTLE.
  - SETTLE: j = k = 0 for SETTLE_CYCLES cycles, counted down, then CHECK.
  - CHECK (cycle N+2+SETTLE_CYCLES): compare q_in to expected, j = k = 0.
    - Match: go to IDLE with done=1 in the next cycle.
    - Mismatch and retry counter < MAX_RETRY: increment the counter; go to DRIVE with excitation computed from q_in sampled in CHECK.
    - Mismatch and counter == MAX_RETRY: go to IDLE with err=1 and err_bits = expected ^ q_in.
- Latency: with no retries, done is high in cycle N+3+SETTLE_CYCLES, together with req_ready=1. Each retry adds 2+SETTLE_CYCLES cycles.
- Back-to-back: a request presented in a done or err cycle is accepted in that cycle. req_valid while busy is ignored; there is no queueing.
- No-op request (LOAD target equal to q_in, or TOGGLE mask 0): runs the full sequence with j = k = 0 and ends with done.
- done and err are never high in the same cycle.
- Reset mid-operation: abort immediately, no done/err pulse, outputs return to their reset values.

Decomposition:
- Package jk_drv_pkg holds:
  - state enum {IDLE, DRIVE, SETTLE, CHECK};
  - mode constants MODE_LOAD = 1'b0, MODE_TOGGLE = 1'b1;
  - retry and settle counter width localparams derived via $clog2.
- Sub-module jk_excite_enc: purely combinational (q, expected, mode, first) -> (j, k) per WIDTH, instantiated once.

Test Plan:
Setup: WIDTH=8, SETTLE_CYCLES=1, MAX_RETRY=2; the bench models the JK bank with fault injection.
1. q=0x00, LOAD 0xA5 accepted cycle N -> j=0xA5, k=0x00 in N+1 only; q=0xA5; done in N+4; err=0.
2. q=0xF0, LOAD 0x3C -> j=0x0C, k=0xC0 for one cycle; q=0x3C; done.
3. q=0x5A, TOGGLE mask 0xFF -> j=k=0xFF for one cycle; q=0xA5; done in N+4.
4. Bank bit 0 stuck at 0, q=0x00, LOAD 0x01 -> three DRIVE cycles (N+1, N+4, N+7), each with j=0x01; err in N+10; err_bits=0x01; no done.
5. rst pulsed low during SETTLE -> j=k=0 and busy=0 immediately, no done/err pulse; a new LOAD 0x0F after release completes normally.
6. req_valid held high with LOAD 0x11 then LOAD 0x22 -> second request accepted in the first's done cycle; final q=0x22; two done pulses 4 cycles apart.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared types and sizing helpers for the JK excitation driver
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Bits needed to hold a counter value in 0..max_val (never less than one bit)
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_MAX_RETRY     = 2;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam int RETRY_W           = cnt_w(DEF_MAX_RETRY);
  localparam int SETTLE_W          = cnt_w(DEF_SETTLE_CYCLES);

endpackage

// File: rtl/jk_excite_enc.sv
// rtl/jk_excite_enc.sv - per-bit J/K excitation from current Q and target
module jk_excite_enc
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] expected,
  input  logic             mode,
  input  logic             first,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  // First TOGGLE drive uses the 11 code on the mask; everything else steers toward expected
  always_comb begin
    if (first && (mode == MODE_TOGGLE)) begin
      j = expected ^ q;
      k = expected ^ q;
    end else begin
      j = ~q & expected;
      k = q & ~expected;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives a JK bank, verifies Q and retries on mismatch
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits
);

  localparam int RW = cnt_w(MAX_RETRY);
  localparam int SW = cnt_w(SETTLE_CYCLES);

  state_t           state;
  logic [WIDTH-1:0] expected;
  logic [RW-1:0]    retry_cnt;
  logic [SW-1:0]    settle_cnt;

  logic [WIDTH-1:0] acc_exp;
  logic [WIDTH-1:0] enc_exp;
  logic [WIDTH-1:0] enc_j;
  logic [WIDTH-1:0] enc_k;
  logic             enc_first;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // In IDLE the encoder sees the incoming request; in CHECK it sees the stored target
  assign acc_exp   = (req_mode == MODE_TOGGLE) ? (q_in ^ req_data) : req_data;
  assign enc_first = (state == IDLE);
  assign enc_exp   = enc_first ? acc_exp : expected;

  jk_excite_enc #(.WIDTH(WIDTH)) u_enc (
    .q        (q_in),
    .expected (enc_exp),
    .mode     (req_mode),
    .first    (enc_first),
    .j        (enc_j),
    .k        (enc_k)
  );

  // Sequencer: accept, drive one cycle, settle, check, then retry or finish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      expected   <= '0;
      retry_cnt  <= '0;
      settle_cnt <= '0;
      j          <= '0;
      k          <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_bits   <= '0;
    end else begin
      j    <= '0;
      k    <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            expected  <= acc_exp;
            retry_cnt <= '0;
            err_bits  <= '0;
            j         <= enc_j;
            k         <= enc_k;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        CHECK: begin
          if (q_in == expected) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + RW'(1);
            j         <= enc_j;
            k         <= enc_k;
            state     <= DRIVE;
          end else begin
            err      <= 1'b1;
            err_bits <= expected ^ q_in;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - self-checking bench with JK bank model and transaction-level reference
module tb_jk_excitation_driver;

  localparam int MAX_RETRY = 2;
  localparam int SC        = 1;
  localparam int P         = 2 + SC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_mode = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] bank_q = 8'h00;
  logic [7:0] j, k, err_bits;
  logic       busy, done, err;

  logic [7:0] pre_val = 8'h00;
  logic       pre_en = 1'b0;
  logic [7:0] stuck0 = 8'h00;
  int         cyc = 0;
  int         errs = 0;
  int         checks = 0;
  logic       chk_en = 1'b0;

  // Reference model state
  logic       m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_exp = 8'h00;
  logic [7:0] e_j = 8'h00, e_k = 8'h00, e_eb = 8'h00;
  logic       e_done = 1'b0, e_err = 1'b0;

  jk_excitation_driver #(.WIDTH(8), .SETTLE_CYCLES(SC), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .q_in      (bank_q),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_bits  (err_bits)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // JK bank: Q+ = J&~Q | ~K&Q, with stuck-at-0 fault mask and preload
  always @(posedge clk) begin
    if (pre_en) bank_q <= pre_val;
    else        bank_q <= ((~bank_q & j) | (bank_q & ~k)) & ~stuck0;
  end

  // Transaction timeline: drive at t=1+a*P, check at t=(a+1)*P, outcome visible one cycle later
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 1'b0; m_t = 0; e_j = 8'h00; e_k = 8'h00;
      e_done = 1'b0; e_err = 1'b0; e_eb = 8'h00;
    end else begin
      e_j = 8'h00; e_k = 8'h00; e_done = 1'b0; e_err = 1'b0;
      if (!m_act) begin
        if (req_valid) begin
          m_exp = req_mode ? (bank_q ^ req_data) : req_data;
          e_eb  = 8'h00;
          if (req_mode) begin
            e_j = req_data; e_k = req_data;
          end else begin
            e_j = ~bank_q & req_data; e_k = bank_q & ~req_data;
          end
          m_act = 1'b1;
          m_t   = 1;
        end
      end else begin
        if (m_t % P == 0) begin
          if (bank_q == m_exp) begin
            e_done = 1'b1; m_act = 1'b0;
          end else if (m_t / P - 1 < MAX_RETRY) begin
            e_j = ~bank_q & m_exp; e_k = bank_q & ~m_exp;
          end else begin
            e_err = 1'b1; e_eb = m_exp ^ bank_q; m_act = 1'b0;
          end
        end
        m_t = m_t + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_j", j, e_j);
      chk("cyc_k", k, e_k);
      chk("cyc_done", done, e_done);
      chk("cyc_err", err, e_err);
      chk("cyc_err_bits", err_bits, e_eb);
      chk("cyc_busy", busy, m_act);
      chk("cyc_ready", req_ready, !m_act);
      chk("cyc_excl", done && err, 0);
    end
  end

  task automatic set_q(input logic [7:0] v);
    @(negedge clk);
    pre_val = v; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic op(input logic m, input logic [7:0] d, output int acc, output int dn,
                    output int er, output int drv, output logic [7:0] j1, output logic [7:0] k1);
    acc = -1; dn = -1; er = -1; drv = 0; j1 = 8'h00; k1 = 8'h00;
    @(negedge clk);
    req_mode = m; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 40 && dn < 0 && er < 0; i++) begin
      if (acc < 0 && req_ready) acc = cyc;
      @(negedge clk);
      if (acc >= 0) begin
        req_valid = 1'b0;
        if ((j | k) != 8'h00) begin
          if (drv == 0) begin j1 = j; k1 = k; end
          drv++;
        end
        if (done) dn = cyc;
        if (err)  er = cyc;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int acc, dn, er, drv, a1, a2, d1, d2;
    logic [7:0] j1, k1;

    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", req_ready, 1);
    chk("rst_j", j, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: LOAD 0xA5 from 0x00
    set_q(8'h00);
    op(1'b0, 8'hA5, acc, dn, er, drv, j1, k1);
    chk("t1_j", j1, 8'hA5); chk("t1_k", k1, 8'h00); chk("t1_drives", drv, 1);
    chk("t1_lat", dn - acc, 4); chk("t1_err", er, -1); chk("t1_q", bank_q, 8'hA5);

    // 2: LOAD 0x3C from 0xF0
    set_q(8'hF0);
    op(1'b0, 8'h3C, acc, dn, er, drv, j1, k1);
    chk("t2_j", j1, 8'h0C); chk("t2_k", k1, 8'hC0); chk("t2_lat", dn - acc, 4);
    chk("t2_q", bank_q, 8'h3C);

    // No-op LOAD (target equals Q) and no-op TOGGLE (mask 0)
    op(1'b0, 8'h3C, acc, dn, er, drv, j1, k1);
    chk("noop_load_drives", drv, 0); chk("noop_load_lat", dn - acc, 4);
    op(1'b1, 8'h00, acc, dn, er, drv, j1, k1);
    chk("noop_tog_drives", drv, 0); chk("noop_tog_lat", dn - acc, 4);

    // 3: TOGGLE 0xFF from 0x5A
    set_q(8'h5A);
    op(1'b1, 8'hFF, acc, dn, er, drv, j1, k1);
    chk("t3_j", j1, 8'hFF); chk("t3_k", k1, 8'hFF); chk("t3_lat", dn - acc, 4);
    chk("t3_q", bank_q, 8'hA5);

    // 4: bit 0 stuck at 0, retries exhaust
    set_q(8'h00);
    stuck0 = 8'h01;
    op(1'b0, 8'h01, acc, dn, er, drv, j1, k1);
    chk("t4_j", j1, 8'h01); chk("t4_drives", drv, 3); chk("t4_err_lat", er - acc, 10);
    chk("t4_done", dn, -1); chk("t4_err_bits", err_bits, 8'h01);
    stuck0 = 8'h00;

    // 5: reset during SETTLE
    set_q(8'h00);
    @(negedge clk);
    req_mode = 1'b0; req_data = 8'h33; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5_busy_settle", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_j", j, 0); chk("t5_rst_k", k, 0); chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0); chk("t5_rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    op(1'b0, 8'h0F, acc, dn, er, drv, j1, k1);
    chk("t5_j", j1, 8'h0C); chk("t5_k", k1, 8'h30); chk("t5_lat", dn - acc, 4);
    chk("t5_q", bank_q, 8'h0F);

    // 6: back-to-back with req_valid held high
    a1 = -1; a2 = -1; d1 = -1; d2 = -1;
    @(negedge clk);
    req_mode = 1'b0; req_data = 8'h11; req_valid = 1'b1;
    for (int i = 0; i < 40 && d2 < 0; i++) begin
      if (req_ready && req_valid) begin
        if (a1 < 0) a1 = cyc;
        else if (a2 < 0 && d1 >= 0) a2 = cyc;
      end
      @(negedge clk);
      if (a1 >= 0 && req_data == 8'h11) req_data = 8'h22;
      if (a2 >= 0) req_valid = 1'b0;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else        d2 = cyc;
      end
    end
    req_valid = 1'b0;
    chk("t6_first_lat", d1 - a1, 4); chk("t6_accept_in_done", a2, d1);
    chk("t6_gap", d2 - d1, 4); chk("t6_q", bank_q, 8'h22);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
